// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit seven-segment counter:
// BCD digit type, segment encoding table ({g,f,e,d,c,b,a}, active-high) and blank pattern.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to seven-segment decode with a blank override.
module seg7_decoder
  import seg7_pkg::*;
(
  input  bcd_digit_t  digit,
  input  logic        blank,
  output logic [6:0]  segments
);

  // Codes above 9 cannot occur in the counter; they decode to blank for safety.
  always_comb begin
    segments = SEG_BLANK;
    if (!blank && digit <= 4'd9) segments = SEG_TABLE[digit];
  end

endmodule

// File: rtl/seg7_multidigit_counter.sv
// DIGITS-wide BCD up/down counter on a prescaled tick, driving a time-multiplexed
// seven-segment display. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_multidigit_counter
  import seg7_pkg::*;
#(
  parameter int MAX_COUNT = 10_000_000,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_down,
  input  logic                  pause,
  input  logic                  clear,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            segments,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   value_bcd
);

  localparam int PW = $clog2(MAX_COUNT);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;

  logic [PW-1:0]     pres_q, pres_d;
  logic [VW-1:0]     value_q, value_d, bcd_step;
  logic              tick_q, tick_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]        segments_q, segments_d;
  logic              pres_wrap, scan_wrap, carry, blank;
  bcd_digit_t        cur_digit;

  assign pres_wrap = (pres_q == PW'(MAX_COUNT - 1));
  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));

  // Ripple BCD step: carry (up) or borrow (down) moves up while digits wrap.
  always_comb begin
    bcd_step = value_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_down) begin
          if (value_q[i*4 +: 4] == 4'd9) bcd_step[i*4 +: 4] = 4'd0;
          else begin
            bcd_step[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (value_q[i*4 +: 4] == 4'd0) bcd_step[i*4 +: 4] = 4'd9;
          else begin
            bcd_step[i*4 +: 4] = value_q[i*4 +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Clear beats pause and tick; pause freezes prescaler and count only.
  always_comb begin
    pres_d  = pres_q + PW'(1);
    value_d = value_q;
    tick_d  = 1'b0;
    if (clear) begin
      pres_d  = '0;
      value_d = '0;
    end else if (pause) begin
      pres_d  = pres_q;
    end else if (pres_wrap) begin
      pres_d  = '0;
      value_d = bcd_step;
      tick_d  = 1'b1;
    end
  end

  always_comb begin
    scan_d = scan_wrap ? '0 : scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    cur_digit   = '0;
    blank       = 1'b0;
    digit_sel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_sel_d[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) cur_digit = value_q[i*4 +: 4];
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank when the selected digit and everything above it are zero; digit 0 always shows.
    blank = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= idx_q && value_q[i*4 +: 4] != 4'd0) blank = 1'b0;
    end
`endif
  end

  seg7_decoder u_decoder (
    .digit    (cur_digit),
    .blank    (blank),
    .segments (segments_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_q      <= '0;
      value_q     <= '0;
      tick_q      <= 1'b0;
      scan_q      <= '0;
      idx_q       <= '0;
      digit_sel_q <= DIGITS'(1);
      segments_q  <= SEG_TABLE[0];
    end else begin
      pres_q      <= pres_d;
      value_q     <= value_d;
      tick_q      <= tick_d;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign segments  = segments_q;
  assign tick      = tick_q;
  assign value_bcd = value_q;

endmodule

// File: doc/seg7_multidigit_counter.md
# seg7_multidigit_counter

Parametrised successor to the single-digit seconds display: a DIGITS-wide BCD counter advanced by a prescaled tick, with up/down and pause control, driving a time-multiplexed common-segment seven-segment display. It sits directly behind the chip I/O pins in place of the single-digit counter. It drives one shared 7-bit segment bus plus a one-hot digit-select bus.

## Interface
- MAX_COUNT, 10_000_000: clock cycles per count tick; legal range ≥ 2.
- DIGITS, 4: number of BCD digits displayed and counted; legal range 1..8.
- SCAN_DIV, 1000: clock cycles each digit is shown before the scan advances; legal range ≥ 1.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- up_down  in  1  1 = count up, 0 = count down; sampled on the tick edge.
- pause  in  1  1 = hold the prescaler and counter; the scan keeps running.
- clear  in  1  synchronous clear of the counter and prescaler.
- digit_sel  out  DIGITS  one-hot active-high select; bit 0 is the least significant digit.
- segments  out  7  {g,f,e,d,c,b,a}, active-high, for the selected digit.
- tick  out  1  one-cycle pulse in the cycle after each count update.
- value_bcd  out  4*DIGITS  current count, packed BCD, digit 0 in [3:0].

## Operation
- Prescaler: counts 0..MAX_COUNT-1, width $clog2(MAX_COUNT).
  - On the edge where it equals MAX_COUNT-1 and pause=0, it wraps to 0 and the counter updates.
  - When pause=1, the prescaler holds and the counter does not update.
- Counter:
  - Up: BCD increment with ripple carry; the all-9s value wraps to 0.
  - Down: BCD decrement with borrow; 0 wraps to the all-9s value.
  - Each digit is always in the range 0..9.
- Clear has priority over a tick and over pause: prescaler=0, value=0, and no tick pulse is generated.
- Scanner:
  - The scan counter runs 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - Pause and clear do not affect the scanner.
  - With DIGITS=1, digit_sel is constant 1.
- Decode, with segments given as hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- digit_sel and segments are registered on the same edge from the same index, so they are always mutually consistent.

## Timing
- Reset values: value_bcd=0, prescaler=0, scan counter=0, digit index=0, digit_sel=1, segments=7'h3F, tick=0.
- The count updates on the prescaler-wrap edge. value_bcd reflects the new value in the following cycle, and tick is high for exactly that one cycle.
- segments and digit_sel lag the digit index and value by one cycle (registered decode).
  - A count change is visible on segments at most 1 cycle after value_bcd changes, for the currently selected digit.
- A change of up_down between ticks has no effect until the next tick edge.
- Clear and tick on the same edge: clear wins and tick stays 0.
- rst asserted mid-operation immediately forces all reset values. Counting resumes from 0, with the full MAX_COUNT period before the first tick.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - Any digit above the most significant non-zero digit drives segments=0.
  - Digit 0 is never blanked, so a count of 0 shows a single "0".
  - digit_sel scanning is unchanged.
- Not defined: every digit is displayed, including leading zeros.
- value_bcd is unaffected by the macro in both cases.

## Structure
- seg7_pkg holds:
  - the 10-entry segment encoding constant table;
  - the blank pattern constant;
  - a 4-bit BCD digit typedef.
- seg7_decoder sub-module: combinational BCD digit plus blank flag to 7-bit segments. It is instantiated once, after the digit mux.
- The prescaler, BCD counter and scanner live in seg7_multidigit_counter itself.

## Test plan
- Reset check (MAX_COUNT=4, DIGITS=2, SCAN_DIV=2): assert rst → digit_sel=01, segments=3F, value_bcd=00, tick=0.
- Count up and wrap: run 100 ticks up → value_bcd passes 09→10 with a correct carry, 99→00 on tick 100, and tick pulses exactly once per 4 cycles.
- Count down and wrap: up_down=0 from 00 → 99, then 98; a digit never reads A–F.
- Pause and clear: pause for 10 cycles → value and prescaler frozen while digit_sel keeps toggling every 2 cycles. Then clear together with a tick edge → value 00, no tick pulse.
- Scan consistency: value 37 → segments=4F while digit_sel=10 and 07 while digit_sel=01, never a mixed pair. With SEG7_LEADING_ZERO_BLANK_EN and value 05 → segments=00 while digit_sel=10.
- Async reset mid-count: rst asserted between clock edges at value 42 → outputs return to reset values before the next edge, and the first tick arrives 4 cycles after release.
